// File: rtl/corescore_jtag_tx_adapter.sv
// FIFO + two-state pacer feeding alt_jtag_atlantic TX (r_dat/r_val/r_ena) from a byte stream.
// Optional delivered-byte/message counters are built when CORESCORE_TX_STATS_EN is defined.
module corescore_jtag_tx_adapter #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    output logic [7:0]            o_r_dat,
    output logic                  o_r_val,
    input  logic                  i_r_ena,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [31:0]           o_bytes,
    output logic [15:0]           o_msgs
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [8:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_d;
    state_t                state_q;
    logic                  r_val_q;
    logic [8:0]            r_word_q;
    logic                  tready;
    logic                  push;
    logic                  pop;

    // Full/empty come from the registered level only, so a pop never frees a slot the same cycle.
    assign tready = (level_q != FULL_LEVEL);
    assign push   = i_tvalid && tready;
    assign pop    = (state_q == IDLE) && (level_q != '0) && i_r_ena;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_tlast, i_tdata};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
        end
    end

    // SEND is a forced gap: the UART may drop ena right after accepting one byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            r_val_q  <= 1'b0;
            r_word_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        r_word_q <= mem_q[rd_ptr_q];
                        r_val_q  <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    r_val_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    r_val_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_tready = tready;
    assign o_r_dat  = r_word_q[7:0];
    assign o_r_val  = r_val_q;
    assign o_level  = level_q;

`ifdef CORESCORE_TX_STATS_EN
    logic [31:0] bytes_q;
    logic [15:0] msgs_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bytes_q <= '0;
            msgs_q  <= '0;
        end else if (r_val_q) begin
            bytes_q <= bytes_q + 32'd1;
            if (r_word_q[8]) begin
                msgs_q <= msgs_q + 16'd1;
            end
        end
    end

    assign o_bytes = bytes_q;
    assign o_msgs  = msgs_q;
`else
    logic unused_tlast;
    assign unused_tlast = r_word_q[8];
    assign o_bytes      = 32'h0;
    assign o_msgs       = 16'h0;
`endif

endmodule

// File: tb/tb_corescore_jtag_tx_adapter.sv
// Directed bench for corescore_jtag_tx_adapter (DEPTH_LOG2 = 4); honours CORESCORE_TX_STATS_EN.
module tb_corescore_jtag_tx_adapter;

`ifdef CORESCORE_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;
    logic [7:0]  o_r_dat;
    logic        o_r_val;
    logic        i_r_ena;
    logic [4:0]  o_level;
    logic [31:0] o_bytes;
    logic [15:0] o_msgs;

    int vectors;
    int miscompares;

    corescore_jtag_tx_adapter #(.DEPTH_LOG2(4)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_r_dat  (o_r_dat),
        .o_r_val  (o_r_val),
        .i_r_ena  (i_r_ena),
        .o_level  (o_level),
        .o_bytes  (o_bytes),
        .o_msgs   (o_msgs)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] front;
        logic       pop_m, push_m, m_send, pre_rdy;
        int         nxt_push, exp_out, gen, cycles;
        int         exp_bytes, exp_msgs;

        vectors     = 0;
        miscompares = 0;
        i_rst = 1'b0; i_tdata = 8'h00; i_tlast = 1'b0; i_tvalid = 1'b0; i_r_ena = 1'b0;

        // 1. reset asserted mid-cycle takes effect immediately
        #2 i_rst = 1'b1;
        #1;
        chk("rst_rval",   32'(o_r_val),  32'd0);
        chk("rst_tready", 32'(o_tready), 32'd1);
        chk("rst_level",  32'(o_level),  32'd0);
        chk("rst_rdat",   32'(o_r_dat),  32'h00);
        chk("rst_bytes",  o_bytes,       32'd0);
        chk("rst_msgs",   32'(o_msgs),   32'd0);
        step(); step();
        i_rst = 1'b0;

        // 2. single byte, ena held: strobe on the second edge after accept
        i_tdata = 8'h41; i_tlast = 1'b1; i_tvalid = 1'b1; i_r_ena = 1'b1;
        step();
        i_tvalid = 1'b0;
        chk("sb_rval_n",  32'(o_r_val), 32'd0);
        chk("sb_level_n", 32'(o_level), 32'd1);
        step();
        chk("sb_rval_n1",  32'(o_r_val), 32'd1);
        chk("sb_rdat_n1",  32'(o_r_dat), 32'h41);
        chk("sb_level_n1", 32'(o_level), 32'd0);
        step();
        chk("sb_rval_n2", 32'(o_r_val), 32'd0);
        chk("sb_rdat_hold", 32'(o_r_dat), 32'h41);
        exp_bytes = 1; exp_msgs = 1;
        chk("sb_bytes", o_bytes,      STATS ? 32'(exp_bytes) : 32'd0);
        chk("sb_msgs",  32'(o_msgs),  STATS ? 32'(exp_msgs)  : 32'd0);
        i_r_ena = 1'b0;

        // 3. fill to full with ena low
        i_tlast = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_tdata = 8'(i); i_tvalid = 1'b1;
            step();
        end
        chk("fill_level",  32'(o_level),  32'd16);
        chk("fill_tready", 32'(o_tready), 32'd0);
        chk("fill_rval",   32'(o_r_val),  32'd0);
        i_tdata = 8'd16;
        step();
        chk("full_hold_level", 32'(o_level), 32'd16);
        // 5b. full plus pop: no write that edge, tready back the cycle after
        i_r_ena = 1'b1;
        step();
        chk("fullpop_level",  32'(o_level),  32'd15);
        chk("fullpop_tready", 32'(o_tready), 32'd1);
        chk("fullpop_rval",   32'(o_r_val),  32'd1);
        chk("fullpop_rdat",   32'(o_r_dat),  32'd0);
        nxt_push = 16; exp_out = 1;
        for (int i = 1; i <= 38; i++) begin
            pre_rdy = o_tready;
            step();
            if (i_tvalid && pre_rdy) begin
                nxt_push++;
                if (nxt_push == 20) begin
                    i_tvalid = 1'b0;
                end else begin
                    i_tdata = 8'(nxt_push);
                    i_tlast = (nxt_push == 19);
                end
            end
            chk("drain_rval", 32'(o_r_val), 32'((i % 2) == 0));
            if ((i % 2) == 0) begin
                chk("drain_rdat", 32'(o_r_dat), 32'(exp_out));
                exp_out++;
            end
        end
        step();
        exp_bytes += 20; exp_msgs += 1;
        chk("drain_count", 32'(exp_out), 32'd20);
        chk("drain_level", 32'(o_level), 32'd0);
        chk("drain_bytes", o_bytes,      STATS ? 32'(exp_bytes) : 32'd0);
        chk("drain_msgs",  32'(o_msgs),  STATS ? 32'(exp_msgs)  : 32'd0);
        i_r_ena = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;

        // 5a. concurrent push and pop at level 5
        for (int i = 0; i < 5; i++) begin
            i_tdata = 8'(8'h50 + i); i_tvalid = 1'b1;
            step();
        end
        chk("cc_level_pre", 32'(o_level), 32'd5);
        i_tdata = 8'h55; i_r_ena = 1'b1;
        step();
        chk("cc_level", 32'(o_level), 32'd5);
        chk("cc_rval",  32'(o_r_val), 32'd1);
        chk("cc_rdat",  32'(o_r_dat), 32'h50);
        i_tvalid = 1'b0; i_r_ena = 1'b0;
        step();
        chk("cc_gap_rval",  32'(o_r_val), 32'd0);
        chk("cc_gap_level", 32'(o_level), 32'd5);
        i_r_ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("cc_drain_rval", 32'(o_r_val), 32'((i % 2) == 0));
            if ((i % 2) == 0) chk("cc_drain_rdat", 32'(o_r_dat), 32'(8'h51 + i / 2));
        end
        exp_bytes += 6;
        chk("cc_level_end", 32'(o_level), 32'd0);
        chk("cc_bytes", o_bytes, STATS ? 32'(exp_bytes) : 32'd0);

        // 4. random ena/valid backpressure against a queue model, 1000 bytes
        m_send = 1'b0; gen = 0; cycles = 0;
        i_r_ena = 1'b0;
        while (cycles < 20000 && (gen < 1000 || q.size() != 0 || m_send || i_tvalid)) begin
            if (!i_tvalid && gen < 1000 && $urandom_range(0, 3) != 0) begin
                i_tdata  = 8'(gen) ^ 8'h3C;
                i_tlast  = ((gen % 5) == 4);
                i_tvalid = 1'b1;
            end
            i_r_ena = 1'($urandom_range(0, 1));
            pop_m   = !m_send && (q.size() != 0) && i_r_ena;
            push_m  = i_tvalid && (q.size() != 16);
            step();
            cycles++;
            chk("bp_rval", 32'(o_r_val), 32'(pop_m));
            if (pop_m) begin
                front = q.pop_front();
                chk("bp_rdat", 32'(o_r_dat), 32'(front[7:0]));
                exp_bytes++;
                if (front[8]) exp_msgs++;
            end
            if (push_m) begin
                q.push_back({i_tlast, i_tdata});
                gen++;
                i_tvalid = 1'b0;
            end
            m_send = pop_m;
            chk("bp_level",  32'(o_level),  32'(q.size()));
            chk("bp_tready", 32'(o_tready), 32'(q.size() != 16));
        end
        step();
        chk("bp_sent",  32'(gen),     32'd1000);
        chk("bp_level_end", 32'(o_level), 32'd0);
        chk("bp_bytes", o_bytes,      STATS ? 32'(exp_bytes) : 32'd0);
        chk("bp_msgs",  32'(o_msgs),  STATS ? 32'(exp_msgs)  : 32'd0);
        i_r_ena = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;

        // 6. reset mid-stream with queued bytes and a strobe in flight
        for (int i = 0; i < 7; i++) begin
            i_tdata = 8'(8'h70 + i); i_tvalid = 1'b1;
            step();
        end
        i_tvalid = 1'b0;
        chk("mr_level_pre", 32'(o_level), 32'd7);
        i_r_ena = 1'b1;
        step();
        chk("mr_rval_pre", 32'(o_r_val), 32'd1);
        #3 i_rst = 1'b1;
        #1;
        chk("mr_rval",   32'(o_r_val),  32'd0);
        chk("mr_rdat",   32'(o_r_dat),  32'h00);
        chk("mr_level",  32'(o_level),  32'd0);
        chk("mr_tready", 32'(o_tready), 32'd1);
        chk("mr_bytes",  o_bytes,       32'd0);
        chk("mr_msgs",   32'(o_msgs),   32'd0);
        step();
        i_rst = 1'b0;
        i_tdata = 8'hA5; i_tlast = 1'b0; i_tvalid = 1'b1;
        step();
        i_tdata = 8'h5A; i_tlast = 1'b1;
        step();
        i_tvalid = 1'b0;
        chk("post_level", 32'(o_level), 32'd1);
        chk("post_rval1", 32'(o_r_val), 32'd1);
        chk("post_rdat1", 32'(o_r_dat), 32'hA5);
        step();
        chk("post_gap", 32'(o_r_val), 32'd0);
        step();
        chk("post_rval2", 32'(o_r_val), 32'd1);
        chk("post_rdat2", 32'(o_r_dat), 32'h5A);
        step();
        chk("post_end_rval", 32'(o_r_val), 32'd0);
        chk("post_bytes", o_bytes,     STATS ? 32'd2 : 32'd0);
        chk("post_msgs",  32'(o_msgs), STATS ? 32'd1 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
